reflow_sequencer: RTL and testbench
===================================

# reflow_sequencer

Closed-loop profile controller for the hotplate plant: drives its `heater_power` input from the measured `current_temp` through a fixed reflow profile. The profile runs ramp-to-soak, soak hold, ramp-to-peak, peak hold, then cool-down. Each cycle it computes a saturated proportional power command, and it enforces ramp timeouts and an over-temperature cutoff. It sits between the top-level command interface (`start`/`abort`) and the hotplate.

## Interface
- `SOAK_TEMP`, 150: soak setpoint, °C units of `current_temp`.
- `PEAK_TEMP`, 240: peak setpoint.
- `COOL_TEMP`, 50: profile ends when temp ≤ this.
- `OVERTEMP`, 300: fault threshold.
- `SOAK_CYCLES`, 200: clock cycles spent in SOAK.
- `PEAK_CYCLES`, 40: clock cycles spent in PEAK.
- `RAMP_TIMEOUT`, 1000: max cycles in either ramp state.
- `KP_SHIFT`, 2: proportional gain as a left shift.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  level-sampled; begins a profile when in IDLE.
- `abort`  in  1  returns to IDLE from any state, and clears a fault.
- `current_temp`  in  16 signed  plant temperature.
- `heater_power`  out  8  registered power command to the plant.
- `setpoint`  out  16 signed  registered active target.
- `state`  out  3  current state encoding.
- `busy`  out  1  high in states 1–5.
- `done`  out  1  one-cycle pulse on profile completion.
- `fault`  out  1  high while in FAULT.

## Operation
- States and encodings:
  - IDLE = 0
  - RAMP_SOAK = 1
  - SOAK = 2
  - RAMP_PEAK = 3
  - PEAK = 4
  - COOL = 5
  - DONE = 6
  - FAULT = 7
- Transitions:
  - IDLE → RAMP_SOAK on `start`.
  - RAMP_SOAK → SOAK when `current_temp` ≥ `SOAK_TEMP`.
  - SOAK → RAMP_PEAK after `SOAK_CYCLES` cycles.
  - RAMP_PEAK → PEAK when `current_temp` ≥ `PEAK_TEMP`.
  - PEAK → COOL after `PEAK_CYCLES` cycles.
  - COOL → DONE when `current_temp` ≤ `COOL_TEMP`.
  - DONE → IDLE unconditionally.
- Faults:
  - RAMP_SOAK or RAMP_PEAK → FAULT when the timer reaches `RAMP_TIMEOUT`-1 without the exit condition being met.
  - States 1–5 → FAULT when `current_temp` ≥ `OVERTEMP`.
  - FAULT → IDLE only on `abort`. `start` is ignored in FAULT.
- Priority within one cycle: over-temp > abort > timeout > normal transition. Over-temp together with `abort` goes to FAULT.
- `start` is ignored outside IDLE. `abort` in IDLE or DONE is harmless and lands in IDLE.
- Timer:
  - 16-bit, cleared on every state change.
  - Increments in states 1–4 and saturates at 0xFFFF.
  - SOAK and PEAK exit on the edge where timer = N-1, so each holds exactly N cycles.
- Setpoint per state:
  - `SOAK_TEMP` in RAMP_SOAK and SOAK.
  - `PEAK_TEMP` in RAMP_PEAK and PEAK.
  - `COOL_TEMP` in COOL.
  - 0 otherwise.
- Power law, applied in heating states 1–4 only:
  - err = setpoint − current_temp, computed at 17-bit signed.
  - power = 0 if err ≤ 0; otherwise min(255, err << `KP_SHIFT`).
  - Compute in ≥ 26 bits before saturating; no wrap is allowed.
- In states 0 and 5–7, `heater_power` = 0.

## Timing
- Reset values: state IDLE, `heater_power` 0, `setpoint` 0, `busy` 0, `done` 0, `fault` 0, timer 0.
- `setpoint`, `state`, `busy`, `done` and `fault` all change on the same edge as the state register.
- `heater_power` at edge k+1 is computed from the `state`/`setpoint` registers and the `current_temp` sampled at edge k+1. That gives one cycle of latency from temperature to power.
  - First nonzero power therefore appears one edge after entry to RAMP_SOAK.
  - Power drops to 0 one edge after entry to COOL or FAULT.
- `done` is high for exactly the one cycle spent in DONE.
- Asynchronous reset mid-profile forces all outputs to their reset values immediately, and the profile does not resume.

## Structure
- Package `reflow_pkg`:
  - 3-bit state enum.
  - Default temperature and cycle-count constants.
  - `TEMP_W` = 16, `POWER_W` = 8.
- Sub-module `reflow_power_calc`: purely combinational error, shift and saturate to 8 bits. The parent registers its output.
- Top level holds the FSM, timer and output registers.

## Test plan
- Reset asserted during RAMP_PEAK with `heater_power` = 255 → outputs read 0 asynchronously; `state` = 0 after release. No activity until a new `start`.
- `start` with temp 25 → `state` 1. Next edge `heater_power` = 255, since err 125 × 4 saturates. With temp driven to 148 → power 8.
- Temp driven to 150 in RAMP_SOAK → `state` 2 for exactly 200 cycles, then 3. Power 0 in SOAK while temp = 150.
- Temp held at 100 in RAMP_SOAK → FAULT after 1000 cycles: `fault` = 1, power 0, `busy` 0. `start` is ignored; `abort` → IDLE with `fault` 0.
- Temp 300 applied in PEAK with `abort` in the same cycle → FAULT, not IDLE.
- Closed loop with the hotplate plant → states run in order 1–6 and `done` pulses exactly once. `start` pulsed mid-profile has no effect; `state` returns to 0.

Source files
------------

// File: rtl/reflow_pkg.sv
// reflow_pkg
// Shared types and default constants for the reflow profile controller:
// state encoding, data widths and the default profile temperatures/durations.
package reflow_pkg;

  localparam int TEMP_W  = 16;
  localparam int POWER_W = 8;
  localparam int TIMER_W = 16;

  localparam int DEF_SOAK_TEMP    = 150;
  localparam int DEF_PEAK_TEMP    = 240;
  localparam int DEF_COOL_TEMP    = 50;
  localparam int DEF_OVERTEMP     = 300;
  localparam int DEF_SOAK_CYCLES  = 200;
  localparam int DEF_PEAK_CYCLES  = 40;
  localparam int DEF_RAMP_TIMEOUT = 1000;
  localparam int DEF_KP_SHIFT     = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_SOAK = 3'd1,
    ST_SOAK      = 3'd2,
    ST_RAMP_PEAK = 3'd3,
    ST_PEAK      = 3'd4,
    ST_COOL      = 3'd5,
    ST_DONE      = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  // States in which the heater is driven by the proportional law.
  function automatic logic is_heating(input state_e s);
    return (s == ST_RAMP_SOAK) || (s == ST_SOAK) ||
           (s == ST_RAMP_PEAK) || (s == ST_PEAK);
  endfunction

  // States that count as an active profile (heating plus cool-down).
  function automatic logic is_busy(input state_e s);
    return is_heating(s) || (s == ST_COOL);
  endfunction

endpackage

// File: rtl/reflow_power_calc.sv
// reflow_power_calc
// Combinational proportional power law: err = setpoint - temp (17-bit signed),
// power = 0 for err <= 0, otherwise min(255, err << KP_SHIFT).
// Ports:
//   setpoint_i  in  16 signed  active target temperature
//   temp_i      in  16 signed  measured plant temperature
//   power_o     out 8          saturated power command (unregistered)
module reflow_power_calc
  import reflow_pkg::*;
#(
  parameter int KP_SHIFT = DEF_KP_SHIFT
) (
  input  logic signed [TEMP_W-1:0] setpoint_i,
  input  logic signed [TEMP_W-1:0] temp_i,
  output logic        [POWER_W-1:0] power_o
);

  // Wide enough that the shifted error can never wrap for any 16-bit inputs.
  localparam int CALC_W = 26;

  logic signed [TEMP_W:0]   err;
  logic signed [CALC_W-1:0] err_ext;
  logic signed [CALC_W-1:0] scaled;

  always_comb begin
    err     = {setpoint_i[TEMP_W-1], setpoint_i} - {temp_i[TEMP_W-1], temp_i};
    err_ext = {{(CALC_W-TEMP_W-1){err[TEMP_W]}}, err};
    scaled  = err_ext <<< KP_SHIFT;
    power_o = '0;
    if (err[TEMP_W] || (err == '0)) begin
      power_o = '0;
    end else if (scaled[CALC_W-1:POWER_W] != '0) begin
      // scaled is known positive here, so any high bit means > 255
      power_o = '1;
    end else begin
      power_o = scaled[POWER_W-1:0];
    end
  end

endmodule

// File: rtl/reflow_sequencer.sv
// reflow_sequencer
// Closed-loop reflow profile controller: walks the hotplate through
// ramp-to-soak, soak, ramp-to-peak, peak, cool-down, with ramp timeouts and
// an over-temperature cutoff, and drives a registered proportional power.
// Ports:
//   clk           in   1          clock
//   reset         in   1          asynchronous, active-high
//   start         in   1          begins a profile from IDLE (level-sampled)
//   abort         in   1          returns to IDLE from any state, clears fault
//   current_temp  in   16 signed  plant temperature
//   heater_power  out  8          registered power command
//   setpoint      out  16 signed  registered active target
//   state         out  3          current state encoding
//   busy          out  1          high while a profile is active (states 1-5)
//   done          out  1          one-cycle pulse in DONE
//   fault         out  1          high while in FAULT
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for start, heater off
// RAMP_SOAK | heating toward SOAK_TEMP, ramp timeout armed
// SOAK      | hold at SOAK_TEMP for SOAK_CYCLES
// RAMP_PEAK | heating toward PEAK_TEMP, ramp timeout armed
// PEAK      | hold at PEAK_TEMP for PEAK_CYCLES
// COOL      | heater off until temp <= COOL_TEMP
// DONE      | single-cycle completion, back to IDLE
// FAULT     | heater off, latched until abort
module reflow_sequencer
  import reflow_pkg::*;
#(
  parameter int SOAK_TEMP    = DEF_SOAK_TEMP,
  parameter int PEAK_TEMP    = DEF_PEAK_TEMP,
  parameter int COOL_TEMP    = DEF_COOL_TEMP,
  parameter int OVERTEMP     = DEF_OVERTEMP,
  parameter int SOAK_CYCLES  = DEF_SOAK_CYCLES,
  parameter int PEAK_CYCLES  = DEF_PEAK_CYCLES,
  parameter int RAMP_TIMEOUT = DEF_RAMP_TIMEOUT,
  parameter int KP_SHIFT     = DEF_KP_SHIFT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic signed [TEMP_W-1:0]  current_temp,
  output logic        [POWER_W-1:0] heater_power,
  output logic signed [TEMP_W-1:0]  setpoint,
  output logic        [2:0]         state,
  output logic                      busy,
  output logic                      done,
  output logic                      fault
);

  localparam logic signed [TEMP_W-1:0] SOAK_T = TEMP_W'(SOAK_TEMP);
  localparam logic signed [TEMP_W-1:0] PEAK_T = TEMP_W'(PEAK_TEMP);
  localparam logic signed [TEMP_W-1:0] COOL_T = TEMP_W'(COOL_TEMP);
  localparam logic signed [TEMP_W-1:0] OVER_T = TEMP_W'(OVERTEMP);

  // Hold states exit on the edge where the timer shows N-1, giving N cycles.
  localparam logic [TIMER_W-1:0] SOAK_LAST = TIMER_W'(SOAK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PEAK_LAST = TIMER_W'(PEAK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RAMP_LAST = TIMER_W'(RAMP_TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic        [TIMER_W-1:0] timer_q, timer_d;
  logic        [POWER_W-1:0] power_q, power_d, power_law;
  logic signed [TEMP_W-1:0]  setpoint_q, setpoint_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      fault_q, fault_d;
  logic                      over_temp;
  logic                      ramp_tmo;

  function automatic logic signed [TEMP_W-1:0] setpoint_for(input state_e s);
    case (s)
      ST_RAMP_SOAK, ST_SOAK: return SOAK_T;
      ST_RAMP_PEAK, ST_PEAK: return PEAK_T;
      ST_COOL:               return COOL_T;
      default:               return '0;
    endcase
  endfunction

  // Power is computed from the registered setpoint so it lags state by a cycle.
  reflow_power_calc #(
    .KP_SHIFT (KP_SHIFT)
  ) u_power_calc (
    .setpoint_i (setpoint_q),
    .temp_i     (current_temp),
    .power_o    (power_law)
  );

  always_comb begin
    state_d   = state_q;
    over_temp = is_busy(state_q) && (current_temp >= OVER_T);
    ramp_tmo  = (timer_q == RAMP_LAST);

    if (over_temp) begin
      state_d = ST_FAULT;
    end else if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (start) state_d = ST_RAMP_SOAK;
        ST_RAMP_SOAK: begin
          // Reaching the target on the last allowed cycle still counts.
          if (current_temp >= SOAK_T) state_d = ST_SOAK;
          else if (ramp_tmo)          state_d = ST_FAULT;
        end
        ST_SOAK:      if (timer_q == SOAK_LAST) state_d = ST_RAMP_PEAK;
        ST_RAMP_PEAK: begin
          if (current_temp >= PEAK_T) state_d = ST_PEAK;
          else if (ramp_tmo)          state_d = ST_FAULT;
        end
        ST_PEAK:      if (timer_q == PEAK_LAST) state_d = ST_COOL;
        ST_COOL:      if (current_temp <= COOL_T) state_d = ST_DONE;
        ST_DONE:      state_d = ST_IDLE;
        ST_FAULT:     state_d = ST_FAULT;
      endcase
    end

    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (is_heating(state_q) && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end

    power_d    = is_heating(state_q) ? power_law : '0;
    setpoint_d = setpoint_for(state_d);
    busy_d     = is_busy(state_d);
    done_d     = (state_d == ST_DONE);
    fault_d    = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      power_q    <= '0;
      setpoint_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      power_q    <= power_d;
      setpoint_q <= setpoint_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
    end
  end

  assign state        = state_q;
  assign heater_power = power_q;
  assign setpoint     = setpoint_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_reflow_sequencer.sv
// tb_reflow_sequencer
// Self-checking bench for reflow_sequencer: a vector table from reset,
// hand-written multi-cycle sequences, a closed loop with a simple plant and a
// randomized run, all checked every cycle against a behavioural profile model.
module tb_reflow_sequencer;

  logic               clk;
  logic               reset;
  logic               start;
  logic               abort;
  logic signed [15:0] current_temp;
  logic        [7:0]  heater_power;
  logic signed [15:0] setpoint;
  logic        [2:0]  state;
  logic               busy;
  logic               done;
  logic               fault;

  int checks = 0;
  int errors = 0;

  reflow_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .current_temp (current_temp),
    .heater_power (heater_power),
    .setpoint     (setpoint),
    .state        (state),
    .busy         (busy),
    .done         (done),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural profile model ----------------
  // Phase numbers follow the documented state encodings; m_cnt is the number
  // of completed cycles spent in the current phase.
  int m_state, m_cnt, m_power;

  function automatic int sp_of(int s);
    if (s == 1 || s == 2) return 150;
    if (s == 3 || s == 4) return 240;
    if (s == 5) return 50;
    return 0;
  endfunction

  function automatic int pw(int sp, int t);
    int e;
    e = sp - t;
    if (e <= 0) return 0;
    if (e * 4 > 255) return 255;
    return e * 4;
  endfunction

  function automatic int next_phase(int s, int cnt, bit st, bit ab, int t);
    if (s >= 1 && s <= 5 && t >= 300) return 7;
    if (ab) return 0;
    case (s)
      0: return st ? 1 : 0;
      1: return (t >= 150) ? 2 : ((cnt == 999) ? 7 : 1);
      2: return (cnt == 199) ? 3 : 2;
      3: return (t >= 240) ? 4 : ((cnt == 999) ? 7 : 3);
      4: return (cnt == 39) ? 5 : 4;
      5: return (t <= 50) ? 6 : 5;
      6: return 0;
      default: return 7;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_power = 0;
  endtask

  task automatic model_step(bit st, bit ab, int t);
    int ns;
    m_power = (m_state >= 1 && m_state <= 4) ? pw(sp_of(m_state), t) : 0;
    ns = next_phase(m_state, m_cnt, st, ab, t);
    if (ns == m_state) m_cnt++;
    else m_cnt = 0;
    m_state = ns;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, clock once, step the model and compare every output.
  task automatic tick(bit st, bit ab, int t);
    start        = st;
    abort        = ab;
    current_temp = 16'(t);
    @(posedge clk);
    #1;
    model_step(st, ab, t);
    chk("model_state",    state,             m_state);
    chk("model_power",    heater_power,      m_power);
    chk("model_setpoint", $signed(setpoint), sp_of(m_state));
    chk("model_busy",     busy,              (m_state >= 1 && m_state <= 5) ? 1 : 0);
    chk("model_done",     done,              (m_state == 6) ? 1 : 0);
    chk("model_fault",    fault,             (m_state == 7) ? 1 : 0);
  endtask

  typedef struct {
    bit st; bit ab; int t;
    int e_state; int e_pow; int e_sp; bit e_busy; bit e_done; bit e_fault;
  } vec_t;

  vec_t vecs[$];
  int   seq[$];
  int   exp_seq[7];

  initial begin
    int cnt, t, last, dones, r;

    reset = 1'b1; start = 1'b0; abort = 1'b0; current_temp = '0;
    model_reset();
    #3;
    chk("rst_state", state, 0);
    chk("rst_power", heater_power, 0);
    chk("rst_setpoint", $signed(setpoint), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    #20;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- vector table ----------------
    vecs.push_back('{1, 0, 25,     1, 0,   150, 1, 0, 0});
    vecs.push_back('{0, 0, 25,     1, 255, 150, 1, 0, 0});
    vecs.push_back('{0, 0, 148,    1, 8,   150, 1, 0, 0});
    vecs.push_back('{0, 0, 149,    1, 4,   150, 1, 0, 0});
    vecs.push_back('{0, 0, 150,    2, 0,   150, 1, 0, 0});
    vecs.push_back('{0, 0, 150,    2, 0,   150, 1, 0, 0});
    vecs.push_back('{0, 0, 140,    2, 40,  150, 1, 0, 0});
    vecs.push_back('{0, 1, 100,    0, 200, 0,   0, 0, 0});
    vecs.push_back('{0, 0, 100,    0, 0,   0,   0, 0, 0});
    vecs.push_back('{1, 1, 100,    0, 0,   0,   0, 0, 0});
    vecs.push_back('{1, 0, -32768, 1, 0,   150, 1, 0, 0});
    vecs.push_back('{0, 0, -32768, 1, 255, 150, 1, 0, 0});
    vecs.push_back('{0, 0, 32767,  7, 0,   0,   0, 0, 1});
    vecs.push_back('{1, 0, 100,    7, 0,   0,   0, 0, 1});
    vecs.push_back('{0, 1, 100,    0, 0,   0,   0, 0, 0});
    vecs.push_back('{0, 0, 305,    0, 0,   0,   0, 0, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].st, vecs[i].ab, vecs[i].t);
      chk($sformatf("vec%0d_state", i), state, vecs[i].e_state);
      chk($sformatf("vec%0d_power", i), heater_power, vecs[i].e_pow);
      chk($sformatf("vec%0d_setpoint", i), $signed(setpoint), vecs[i].e_sp);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("vec%0d_fault", i), fault, vecs[i].e_fault);
    end

    // ---------------- soak length, over-temp beats abort ----------------
    tick(1, 0, 150);
    tick(0, 0, 150);
    chk("soak_entry", state, 2);
    cnt = 1;
    for (int i = 0; i < 300; i++) begin
      tick(0, 0, 150);
      if (state == 3'd2) begin
        cnt++;
        if (cnt == 50) chk("soak_power", heater_power, 0);
      end else break;
    end
    chk("soak_len", cnt, 200);
    chk("soak_exit", state, 3);
    tick(0, 0, 240);
    chk("peak_entry", state, 4);
    tick(0, 1, 300);
    chk("ot_abort_state", state, 7);
    chk("ot_abort_fault", fault, 1);
    tick(0, 1, 100);
    chk("ot_abort_clear", state, 0);

    // ---------------- ramp timeout ----------------
    tick(1, 0, 100);
    cnt = 1;
    for (int i = 0; i < 1100; i++) begin
      tick(0, 0, 100);
      if (state == 3'd1) cnt++;
      else break;
    end
    chk("tmo_len", cnt, 1000);
    chk("tmo_state", state, 7);
    chk("tmo_fault", fault, 1);
    tick(0, 0, 100);
    chk("tmo_power", heater_power, 0);
    chk("tmo_busy", busy, 0);
    tick(1, 0, 100);
    chk("tmo_start_ignored", state, 7);
    tick(0, 1, 100);
    chk("tmo_abort_state", state, 0);
    chk("tmo_abort_fault", fault, 0);

    // ---------------- async reset during RAMP_PEAK ----------------
    tick(1, 0, 150);
    for (int i = 0; i < 300; i++) begin
      tick(0, 0, 150);
      if (state == 3'd3) break;
    end
    chk("rp_reached", state, 3);
    tick(0, 0, 100);
    chk("rp_power", heater_power, 255);
    #2 reset = 1'b1;
    #1;
    chk("arst_power", heater_power, 0);
    chk("arst_setpoint", $signed(setpoint), 0);
    chk("arst_state", state, 0);
    chk("arst_busy", busy, 0);
    chk("arst_fault", fault, 0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk("arst_release_state", state, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 100);

    // ---------------- closed loop with a simple plant ----------------
    exp_seq = '{1, 2, 3, 4, 5, 6, 0};
    t = 25; last = 0; dones = 0;
    tick(1, 0, t);
    for (int i = 0; i < 3000; i++) begin
      if (int'(state) != last) begin
        seq.push_back(int'(state));
        last = int'(state);
      end
      if (done) dones++;
      if (state == 3'd0) break;
      t = (m_power > 0) ? t + (m_power + 15) / 16 : t - 1;
      tick((i == 100) || (i == 300), 0, t);
    end
    chk("loop_end_state", state, 0);
    chk("loop_done_count", dones, 1);
    chk("loop_seq_len", seq.size(), 7);
    for (int k = 0; k < 7; k++)
      if (k < seq.size()) chk($sformatf("loop_seq%0d", k), seq[k], exp_seq[k]);

    // ---------------- randomized run against the model ----------------
    t = 25;
    for (int i = 0; i < 8000; i++) begin
      r = int'($urandom_range(0, 1999));
      if ($urandom_range(0, 2999) == 0) t = 310;
      else begin
        t = (m_power > 0) ? t + (m_power + 15) / 16 : t - 1;
        t = t + int'($urandom_range(0, 2)) - 1;
        if (t < -50) t = -50;
      end
      tick(r < 40, r == 1999, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
